// File: rtl/stack_drain.sv
// Reader-side companion for the hardware LIFO stack: forwards writer pushes,
// tracks occupancy and drains a requested number of entries onto a stream.
module stack_drain #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_push,
    output logic             wr_ready,
    output logic [WIDTH-1:0] stk_in,
    output logic             stk_push,
    output logic             stk_pop,
    input  logic [WIDTH-1:0] stk_out,
    input  logic             start,
    input  logic [DEPTH:0]   count,
    output logic             busy,
    output logic [DEPTH:0]   level,
    output logic             overflow,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] ONE  = (DEPTH+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [DEPTH:0]   remaining, remaining_nxt;
    logic [DEPTH:0]   level_eff, clamp;
    logic             inflight, inflight_last;
    logic             pop, push, deq;
    logic [1:0]       occ_eff;

    logic             head_valid, head_last;
    logic [WIDTH-1:0] head_data;
    logic             tail_valid, tail_last;
    logic [WIDTH-1:0] tail_data;

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign push     = wr_push & wr_ready;
    assign stk_push = push;
    assign stk_in   = wr_data;
    assign stk_pop  = pop & ~reset;

    assign m_data  = head_data;
    assign m_valid = head_valid;
    assign m_last  = head_last;

    assign deq = head_valid & m_ready;

    // A word leaving the buffer this cycle frees its slot for a new pop.
    assign occ_eff = {1'b0, head_valid} + {1'b0, tail_valid} - {1'b0, deq};

    // A push in the start cycle counts toward the clamp.
    assign level_eff = (push && level != FULL) ? level + 1'b1 : level;
    assign clamp     = (count < level_eff) ? count : level_eff;

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pop           = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    remaining_nxt = clamp;
                    if (clamp != '0) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (remaining != '0 &&
                    (occ_eff + {1'b0, inflight}) < 2'd2) begin
                    pop           = 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == ONE) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (!head_valid && !tail_valid && !inflight)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remaining     <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            remaining     <= remaining_nxt;
            inflight      <= pop;
            inflight_last <= pop && (remaining == ONE);
            if (push) begin
                if (level == FULL) overflow <= 1'b1;
                else               level    <= level + 1'b1;
            end else if (pop) begin
                level <= level - 1'b1;
            end
        end
    end

    // Two-entry skid buffer; the head register drives the stream directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            head_data  <= '0;
            tail_valid <= 1'b0;
            tail_last  <= 1'b0;
            tail_data  <= '0;
        end else if (deq || !head_valid) begin
            if (tail_valid) begin
                head_valid <= 1'b1;
                head_data  <= tail_data;
                head_last  <= tail_last;
                tail_valid <= inflight;
                if (inflight) begin
                    tail_data <= stk_out;
                    tail_last <= inflight_last;
                end
            end else begin
                head_valid <= inflight;
                head_last  <= inflight & inflight_last;
                if (inflight) head_data <= stk_out;
            end
        end else if (inflight) begin
            tail_valid <= 1'b1;
            tail_data  <= stk_out;
            tail_last  <= inflight_last;
        end
    end

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: behavioural stack device plus a queue-based
// reference of pushed words, occupancy and overflow.
module tb_stack_drain;

    localparam int W = 11;
    localparam int D = 7;
    localparam int CAP = 128;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] wr_data;
    logic         wr_push;
    logic         wr_ready;
    logic [W-1:0] stk_in;
    logic         stk_push;
    logic         stk_pop;
    logic [W-1:0] stk_out = '0;
    logic         start;
    logic [D:0]   count;
    logic         busy;
    logic [D:0]   level;
    logic         overflow;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    stack_drain #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .wr_data(wr_data), .wr_push(wr_push), .wr_ready(wr_ready),
        .stk_in(stk_in), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_out(stk_out), .start(start), .count(count),
        .busy(busy), .level(level), .overflow(overflow),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // stack device and stream monitor
    logic [W-1:0] mem [CAP];
    logic [D-1:0] sp = '0;
    logic [W:0]   rx[$];
    int           pop_cnt = 0;
    int           outst = 0;
    logic         stall_q = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic         hold_last = 1'b0;

    // reference model
    logic [W-1:0] ref_q[$];
    logic [W-1:0] exp_q[$];
    int           ref_level = 0;
    bit           ref_ovf = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            sp      <= '0;
            stall_q <= 1'b0;
            outst   <= 0;
        end else begin
            if (stk_push) begin
                mem[sp] <= stk_in;
                sp      <= sp + 1'b1;
            end
            if (stk_pop) begin
                stk_out <= mem[sp - 1'b1];
                sp      <= sp - 1'b1;
                pop_cnt <= pop_cnt + 1;
            end
            if (m_valid && m_ready) rx.push_back({m_last, m_data});
            if (stall_q) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(hold_data));
                chk("hold_last", 32'(m_last), 32'(hold_last));
            end
            chk("outstanding_le2", 32'(outst <= 2), 32'd1);
            stall_q   <= m_valid && !m_ready;
            hold_data <= m_data;
            hold_last <= m_last;
            outst <= outst + int'(stk_pop) - int'(m_valid && m_ready);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(logic [W-1:0] d);
        if (ref_level == CAP) ref_ovf = 1;
        else ref_level++;
        ref_q.push_back(d);
    endtask

    task automatic push(logic [W-1:0] d);
        wr_data = d;
        wr_push = 1'b1;
        tick();
        wr_push = 1'b0;
        model_push(d);
    endtask

    task automatic start_drain(int cnt, bit with_push, logic [W-1:0] pd);
        int n;
        rx.delete();
        exp_q.delete();
        if (with_push) begin
            wr_data = pd;
            wr_push = 1'b1;
            model_push(pd);
        end
        n = (cnt < ref_level) ? cnt : ref_level;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_q.pop_back());
        ref_level -= n;
        count = cnt[D:0];
        start = 1'b1;
        tick();
        start   = 1'b0;
        wr_push = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(n != 0));
    endtask

    task automatic finish_drain(int mode);
        int cyc = 0;
        while (busy && cyc < 400) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = 1'($urandom % 2);
            endcase
            tick();
            cyc++;
        end
        m_ready = 1'b1;
        chk("drain_timeout", 32'(cyc < 400), 32'd1);
        chk("valid_after_drain", 32'(m_valid), 32'd0);
        chk("rx_count", 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
            chk($sformatf("rx_data[%0d]", i), 32'(rx[i][W-1:0]),
                32'(exp_q[i]));
            chk($sformatf("rx_last[%0d]", i), 32'(rx[i][W]),
                32'(i == exp_q.size() - 1));
        end
        chk("level_after_drain", 32'(level), 32'(ref_level));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ref_q.delete();
        ref_level = 0;
        ref_ovf   = 0;
        rx.delete();
    endtask

    initial begin
        int p0;
        int c;
        reset   = 1'b1;
        wr_data = '0;
        wr_push = 1'b0;
        start   = 1'b0;
        count   = '0;
        m_ready = 1'b1;
        do_reset();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_pop", 32'(stk_pop), 32'd0);

        // basic ordered drain with cycle-accurate latency
        push(11'h001);
        push(11'h002);
        push(11'h003);
        chk("t1_level", 32'(level), 32'd3);
        m_ready = 1'b1;
        start_drain(3, 0, '0);
        chk("t1_pop_e0", 32'(stk_pop), 32'd1);
        chk("t1_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        chk("t1_valid_e1", 32'(m_valid), 32'd0);
        tick();
        chk("t1_valid_e2", 32'(m_valid), 32'd1);
        chk("t1_data_e2", 32'(m_data), 32'h003);
        chk("t1_last_e2", 32'(m_last), 32'd0);
        tick();
        chk("t1_data_e3", 32'(m_data), 32'h002);
        chk("t1_last_e3", 32'(m_last), 32'd0);
        tick();
        chk("t1_data_e4", 32'(m_data), 32'h001);
        chk("t1_last_e4", 32'(m_last), 32'd1);
        tick();
        chk("t1_valid_e5", 32'(m_valid), 32'd0);
        chk("t1_busy_e5", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_e6", 32'(busy), 32'd0);
        finish_drain(0);

        // clamp: count larger than level
        push(11'h0AA);
        push(11'h0BB);
        p0 = pop_cnt;
        start_drain(5, 0, '0);
        finish_drain(0);
        chk("t2_pops", 32'(pop_cnt - p0), 32'd2);
        chk("t2_level", 32'(level), 32'd0);

        // back-pressure pattern 1,0,0,1,...
        for (int i = 0; i < 4; i++) push(11'($urandom));
        start_drain(4, 0, '0);
        finish_drain(1);

        // pushes ignored while busy
        push(11'h011);
        push(11'h022);
        push(11'h033);
        m_ready = 1'b0;
        start_drain(2, 0, '0);
        wr_data = 11'h7FF;
        wr_push = 1'b1;
        #1;
        chk("t4_wr_ready", 32'(wr_ready), 32'd0);
        chk("t4_stk_push", 32'(stk_push), 32'd0);
        tick();
        chk("t4_stk_push2", 32'(stk_push), 32'd0);
        tick();
        wr_push = 1'b0;
        finish_drain(0);

        // push in the start cycle drains first
        push(11'h101);
        start_drain(2, 1, 11'h155);
        finish_drain(2);

        // zero count, then drain everything left
        start_drain(0, 0, '0);
        tick();
        chk("t6_no_words", 32'(rx.size()), 32'd0);
        start_drain(200, 0, '0);
        finish_drain(2);
        start_drain(3, 0, '0);
        finish_drain(0);

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            int k;
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++)
                if (ref_level < 120) push(11'($urandom));
            start_drain($urandom_range(0, 10), 1'($urandom % 2),
                        11'($urandom));
            finish_drain(2);
        end

        // reset mid-drain
        for (int i = 0; i < 4; i++) push(11'(i + 16));
        m_ready = 1'b1;
        start_drain(4, 0, '0);
        c = 0;
        while (rx.size() == 0 && c < 20) begin
            tick();
            c++;
        end
        chk("t7_first_word", 32'(rx.size()), 32'd1);
        reset = 1'b1;
        #1;
        chk("t7_pop_in_reset", 32'(stk_pop), 32'd0);
        tick();
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_valid", 32'(m_valid), 32'd0);
        chk("t7_pop", 32'(stk_pop), 32'd0);
        chk("t7_level", 32'(level), 32'd0);
        reset = 1'b0;
        ref_q.delete();
        ref_level = 0;
        ref_ovf   = 0;
        tick();
        chk("t7_pop_after", 32'(stk_pop), 32'd0);
        chk("t7_busy_after", 32'(busy), 32'd0);

        // saturation and sticky overflow
        for (int i = 0; i < CAP; i++) push(11'(i));
        chk("t8_level_full", 32'(level), 32'(ref_level));
        chk("t8_ovf_clear", 32'(overflow), 32'(ref_ovf));
        wr_data = 11'h3C3;
        wr_push = 1'b1;
        #1;
        chk("t8_push_fwd", 32'(stk_push), 32'd1);
        tick();
        wr_push = 1'b0;
        model_push(11'h3C3);
        chk("t8_level_sat", 32'(level), 32'(ref_level));
        chk("t8_ovf_set", 32'(overflow), 32'(ref_ovf));
        push(11'h001);
        tick();
        tick();
        chk("t8_ovf_sticky", 32'(overflow), 32'(ref_ovf));
        chk("t8_level_hold", 32'(level), 32'd128);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
